// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM encoding, mode constants, frame length.
// Used by the transmitter, the matching receiver and benches.
package spi_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        SETUP = S_SETUP,
        SHIFT = S_SHIFT,
        HOLD  = S_HOLD
    } state_t;

    localparam bit CPOL      = 1'b0;
    localparam bit CPHA      = 1'b0;
    localparam bit MSB_FIRST = 1'b1;

    // System clocks from handshake to csN release.
    function automatic int frame_len(input int size, input int clk_div);
        return (2 * size + 2) * clk_div;
    endfunction

endpackage

// File: rtl/spi_master_tx_if.sv
// Word handshake plus outgoing SPI link of the transmitter.
// master = upstream word source, slave = transmitter.
interface spi_master_tx_if #(
    parameter int size = 8
);

    logic [size-1:0] dataIn;
    logic            valid;
    logic            ready;
    logic            sclk;
    logic            mosi;
    logic            csN;
    logic            done;

    modport master (
        output dataIn, valid,
        input  ready, sclk, mosi, csN, done
    );

    modport slave (
        input  dataIn, valid,
        output ready, sclk, mosi, csN, done
    );

endinterface

// File: rtl/spi_clk_div.sv
// Half-period tick generator: one tick every CLK_DIV clocks while run.
// Counter restarts on each tick, so FSM state changes begin a fresh period.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int W = $clog2(CLK_DIV + 1);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (!reset || !run || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/spi_master_tx.sv
// Mode-0 MSB-first SPI transmitter: one word per handshake, framed by csN.
// Outputs are all registered; the divider paces every FSM step.
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int size    = 8,
    parameter int CLK_DIV = 4
) (
    input  logic            clock,
    input  logic            reset,
    spi_master_tx_if.slave  bus
);

    localparam int BW = $clog2(2 * size + 1);
    localparam logic [BW-1:0] LAST_HALF = BW'(2 * size - 1);
    localparam logic [BW-1:0] LAST_FALL = BW'(2 * size - 2);

    state_t          state;
    logic [size-1:0] shreg;
    logic [BW-1:0]   half;
    logic            tick;
    logic            run;

    assign run = (state != IDLE);

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clock(clock),
        .reset(reset),
        .run  (run),
        .tick (tick)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            shreg     <= '0;
            half      <= '0;
            bus.ready <= 1'b0;
            bus.sclk  <= 1'b0;
            bus.mosi  <= 1'b0;
            bus.csN   <= 1'b1;
            bus.done  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    bus.ready <= 1'b1;
                    bus.csN   <= 1'b1;
                    bus.sclk  <= 1'b0;
                    if (bus.valid && bus.ready) begin
                        state     <= SETUP;
                        shreg     <= bus.dataIn;
                        bus.mosi  <= bus.dataIn[size-1];
                        bus.csN   <= 1'b0;
                        bus.ready <= 1'b0;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        state    <= SHIFT;
                        bus.sclk <= 1'b1;
                        half     <= '0;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (half == LAST_HALF) begin
                            state <= HOLD;
                            half  <= '0;
                        end else begin
                            half     <= half + 1'b1;
                            bus.sclk <= ~bus.sclk;
                            // Last falling edge keeps bit 0 on mosi.
                            if (bus.sclk && half != LAST_FALL) begin
                                shreg    <= {shreg[size-2:0], 1'b0};
                                bus.mosi <= shreg[size-2];
                            end
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        state     <= IDLE;
                        bus.csN   <= 1'b1;
                        bus.done  <= 1'b1;
                        bus.mosi  <= 1'b0;
                        bus.ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench: default 8-bit/div-4 instance plus a 16-bit/div-1 instance.
// A per-instance slave model captures mosi on sclk rises and frame stats.
module tb_spi_master_tx;
    import spi_pkg::*;

    localparam int F8  = (2 * 8 + 2) * 4;
    localparam int F16 = (2 * 16 + 2) * 1;

    logic clock = 1'b0;
    logic rst_a;
    logic rst_b;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    spi_master_tx_if #(.size(8))  bus_a ();
    spi_master_tx_if #(.size(16)) bus_b ();

    spi_master_tx #(.size(8), .CLK_DIV(4)) dut_a (
        .clock(clock),
        .reset(rst_a),
        .bus  (bus_a)
    );

    spi_master_tx #(.size(16), .CLK_DIV(1)) dut_b (
        .clock(clock),
        .reset(rst_b),
        .bus  (bus_b)
    );

    // Slave model A
    int starts_a = 0, dones_a = 0;
    int rises_a = 0, low_a = 0, high_a = 0, gap_a = 0;
    int lr_a = 0, ll_a = 0, lh_a = 0, lg_a = 0;
    logic [15:0] cap_a = '0, lc_a = '0;
    logic ps_a = 1'b0, pc_a = 1'b1;

    always @(negedge clock) begin
        if (bus_a.done === 1'b1) dones_a++;
        if (bus_a.csN === 1'b0) begin
            if (pc_a === 1'b1) begin
                starts_a++;
                lg_a = gap_a;
            end
            low_a++;
            if (bus_a.sclk === 1'b1) high_a++;
            if (bus_a.sclk === 1'b1 && ps_a === 1'b0) begin
                rises_a++;
                cap_a = {cap_a[14:0], bus_a.mosi};
            end
        end else begin
            if (pc_a === 1'b0) begin
                lr_a = rises_a; ll_a = low_a;
                lh_a = high_a;  lc_a = cap_a;
                rises_a = 0; low_a = 0; high_a = 0;
                cap_a = '0; gap_a = 0;
            end
            gap_a++;
        end
        ps_a = bus_a.sclk;
        pc_a = bus_a.csN;
    end

    // Slave model B
    int rises_b = 0, low_b = 0, high_b = 0;
    int lr_b = 0, ll_b = 0, lh_b = 0;
    logic [15:0] cap_b = '0, lc_b = '0;
    logic ps_b = 1'b0, pc_b = 1'b1;

    always @(negedge clock) begin
        if (bus_b.csN === 1'b0) begin
            low_b++;
            if (bus_b.sclk === 1'b1) high_b++;
            if (bus_b.sclk === 1'b1 && ps_b === 1'b0) begin
                rises_b++;
                cap_b = {cap_b[14:0], bus_b.mosi};
            end
        end else if (pc_b === 1'b0) begin
            lr_b = rises_b; ll_b = low_b;
            lh_b = high_b;  lc_b = cap_b;
            rises_b = 0; low_b = 0; high_b = 0;
            cap_b = '0;
        end
        ps_b = bus_b.sclk;
        pc_b = bus_b.csN;
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_done(input bit b, input string tag,
                             output int c);
        bit found;
        found = 1'b0;
        c = 0;
        for (int k = 0; k < 400 && !found; k++) begin
            step(1);
            if ((b ? bus_b.done : bus_a.done) === 1'b1) begin
                found = 1'b1;
                c = cyc;
            end
        end
        check({tag, " done seen"}, 32'(found), 32'd1);
    endtask

    int t0, c1, c2, s0, d0, n;
    logic ps;

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.valid  = 1'b1;
        bus_a.dataIn = 8'hFF;
        bus_b.valid  = 1'b0;
        bus_b.dataIn = 16'h0;

        // 1: reset with valid asserted
        step(5);
        check("rst csN",   32'(bus_a.csN),   32'd1);
        check("rst sclk",  32'(bus_a.sclk),  32'd0);
        check("rst mosi",  32'(bus_a.mosi),  32'd0);
        check("rst ready", 32'(bus_a.ready), 32'd0);
        check("rst done",  32'(bus_a.done),  32'd0);
        check("rst starts", 32'(starts_a),   32'd0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.valid = 1'b0;
        step(1);
        check("rel ready", 32'(bus_a.ready), 32'd1);
        check("rel csN",   32'(bus_a.csN),   32'd1);
        step(2);
        check("rel starts", 32'(starts_a),   32'd0);

        // 2: single word A5
        bus_a.dataIn = 8'hA5;
        bus_a.valid  = 1'b1;
        step(1);
        t0 = cyc;
        bus_a.valid  = 1'b0;
        bus_a.dataIn = 8'h00;
        check("a5 csN low",  32'(bus_a.csN),   32'd0);
        check("a5 ready lo", 32'(bus_a.ready), 32'd0);
        check("a5 mosi msb", 32'(bus_a.mosi),  32'd1);
        step(3);
        check("a5 setup sclk", 32'(bus_a.sclk), 32'd0);
        step(1);
        check("a5 first rise", 32'(bus_a.sclk), 32'd1);
        wait_done(1'b0, "a5", c1);
        check("a5 done edge", 32'(c1 - t0), 32'(F8));
        check("a5 csN at done", 32'(bus_a.csN), 32'd1);
        step(1);
        check("a5 done pulse", 32'(bus_a.done), 32'd0);
        check("a5 captured", 32'(lc_a[7:0]), 32'hA5);
        check("a5 rises",    32'(lr_a), 32'd8);
        check("a5 csN low",  32'(ll_a), 32'(F8));
        check("a5 sclk high", 32'(lh_a), 32'd32);

        // 3: back-to-back 00 then FF, valid held
        bus_a.dataIn = 8'h00;
        bus_a.valid  = 1'b1;
        step(1);
        bus_a.dataIn = 8'hFF;
        wait_done(1'b0, "b2b1", c1);
        step(1);
        bus_a.valid = 1'b0;
        check("b2b second start", 32'(bus_a.csN), 32'd0);
        check("b2b cap0",   32'(lc_a[7:0]), 32'h00);
        check("b2b rises0", 32'(lr_a), 32'd8);
        wait_done(1'b0, "b2b2", c2);
        check("b2b done spacing", 32'(c2 - c1), 32'(F8 + 1));
        step(1);
        check("b2b capFF", 32'(lc_a[7:0]), 32'hFF);
        check("b2b gap",   32'(lg_a), 32'd1);

        // 4: data stability and mid-frame valid
        s0 = starts_a;
        bus_a.dataIn = 8'h3C;
        bus_a.valid  = 1'b1;
        step(1);
        bus_a.valid  = 1'b0;
        bus_a.dataIn = 8'hFF;
        step(20);
        bus_a.valid = 1'b1;
        step(1);
        check("stab ready", 32'(bus_a.ready), 32'd0);
        bus_a.valid = 1'b0;
        wait_done(1'b0, "stab", c1);
        step(1);
        check("stab cap", 32'(lc_a[7:0]), 32'h3C);
        step(10);
        check("stab frames", 32'(starts_a - s0), 32'd1);
        check("stab idle csN", 32'(bus_a.csN), 32'd1);

        // 5: abort at the 4th rise of C3
        d0 = dones_a;
        bus_a.dataIn = 8'hC3;
        bus_a.valid  = 1'b1;
        step(1);
        bus_a.valid = 1'b0;
        n = 0;
        ps = 1'b0;
        for (int k = 0; k < 200 && n < 4; k++) begin
            step(1);
            if (bus_a.sclk === 1'b1 && ps === 1'b0) n++;
            ps = bus_a.sclk;
        end
        check("abort rise4", 32'(n), 32'd4);
        rst_a = 1'b0;
        step(1);
        check("abort csN",   32'(bus_a.csN),   32'd1);
        check("abort sclk",  32'(bus_a.sclk),  32'd0);
        check("abort done",  32'(bus_a.done),  32'd0);
        check("abort ready", 32'(bus_a.ready), 32'd0);
        rst_a = 1'b1;
        step(1);
        check("abort rises", 32'(lr_a), 32'd4);
        check("abort ready1", 32'(bus_a.ready), 32'd1);
        step(5);
        check("abort no done", 32'(dones_a - d0), 32'd0);
        bus_a.dataIn = 8'h81;
        bus_a.valid  = 1'b1;
        step(1);
        bus_a.valid = 1'b0;
        wait_done(1'b0, "post", c1);
        step(1);
        check("post cap",   32'(lc_a[7:0]), 32'h81);
        check("post rises", 32'(lr_a), 32'd8);

        // 6: size=16, CLK_DIV=1
        bus_b.dataIn = 16'hBEEF;
        bus_b.valid  = 1'b1;
        step(1);
        t0 = cyc;
        bus_b.valid = 1'b0;
        wait_done(1'b1, "w16", c1);
        check("w16 done edge", 32'(c1 - t0),
              32'(frame_len(16, 1)));
        step(1);
        check("w16 cap",   32'(lc_b), 32'hBEEF);
        check("w16 rises", 32'(lr_b), 32'd16);
        check("w16 csN low", 32'(ll_b), 32'(F16));
        check("w16 sclk high", 32'(lh_b), 32'd16);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
